instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 47 ++++
 rtl/instruction_fetch_if.sv | 42 ++++
 rtl/instruction_fetch_program_counter.sv | 34 +++
 rtl/instruction_fetch.sv | 128 ++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the fetch/decode front end.
// Contents: address and instruction widths, opcode constants, register
// identifiers, the instruction word layout and the fetch FSM state type.
// No ports (package).
// ---------------------------------------------------------------------------
package instruction_fetch_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 28;
  localparam int OP_W    = 4;
  localparam int REG_W   = 8;

  // Opcodes
  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_STO = 4'h1;
  localparam logic [OP_W-1:0] OP_MUL = 4'h2;
  localparam logic [OP_W-1:0] OP_LED = 4'h3;
  localparam logic [OP_W-1:0] OP_JMP = 4'hF;

  // Register identifiers
  localparam logic [REG_W-1:0] REG_R0 = 8'h00;
  localparam logic [REG_W-1:0] REG_R1 = 8'h01;
  localparam logic [REG_W-1:0] REG_R2 = 8'h02;
  localparam logic [REG_W-1:0] REG_R3 = 8'h03;

  // Instruction word layout, MSB first:
  // [27:24] opcode, [23:16] destination, [15:8] source A, [7:0] source B.
  // The immediate overlays both source fields as [15:0].
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] dst;
    logic [REG_W-1:0] src_a;
    logic [REG_W-1:0] src_b;
  } instr_t;

  typedef enum logic {
    ST_START,
    ST_RUN
  } fetch_state_t;

  function automatic logic [ADDR_W-1:0] imm_of(input instr_t w);
    return {w.src_a, w.src_b};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_if
// Bundles the fetch unit's ROM, execute-stage and decode-issue signals.
// Modport master : the fetch unit (drives address and decoded outputs).
// Modport slave  : ROM / execute stage side (drives instruction, stall,
//                  branch redirect).
// Signals:
//   oAddress      PC, ROM address
//   iInstruction  ROM word for oAddress (combinational)
//   iStall        execute stage busy
//   iBranchTaken  redirect request
//   iBranchTarget redirect address
//   oValid        decode register holds an issuable instruction
//   oOperation / oDestination / oSourceA / oSourceB / oImmediate
//                 registered decoded fields
// ---------------------------------------------------------------------------
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  logic [ADDR_W-1:0]  oAddress;
  logic [INSTR_W-1:0] iInstruction;
  logic               iStall;
  logic               iBranchTaken;
  logic [ADDR_W-1:0]  iBranchTarget;
  logic               oValid;
  logic [OP_W-1:0]    oOperation;
  logic [REG_W-1:0]   oDestination;
  logic [REG_W-1:0]   oSourceA;
  logic [REG_W-1:0]   oSourceB;
  logic [ADDR_W-1:0]  oImmediate;

  modport master (
    output oAddress, oValid, oOperation, oDestination, oSourceA, oSourceB, oImmediate,
    input  iInstruction, iStall, iBranchTaken, iBranchTarget
  );

  modport slave (
    input  oAddress, oValid, oOperation, oDestination, oSourceA, oSourceB, oImmediate,
    output iInstruction, iStall, iBranchTaken, iBranchTarget
  );

endinterface

// File: rtl/instruction_fetch_program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
// 16-bit program counter with synchronous reset, load, hold and increment.
// Priority: Reset > load > hold > increment. Increment wraps modulo 2^16.
// Ports:
//   Clock   rising-edge clock
//   Reset   synchronous active-high reset, PC <= 0
//   load    load PC from target
//   hold    keep current PC
//   target  load value
//   pc      current program counter
// ---------------------------------------------------------------------------
module program_counter
  import instruction_fetch_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              load,
  input  logic              hold,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= target;
    end else if (!hold) begin
      pc <= pc + 16'd1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
// Fetch and decode front end. Drives the ROM address from a program counter,
// decodes the returned word into a registered issue slot, consumes local JMPs
// inside fetch, and honours execute-stage stall and branch redirect.
// Ports:
//   Clock  rising-edge clock
//   Reset  synchronous active-high reset
//   bus    instruction_fetch_if.master (ROM, execute and decode signals)
// ---------------------------------------------------------------------------
module instruction_fetch
  import instruction_fetch_pkg::*;
(
  input  logic                  Clock,
  input  logic                  Reset,
  instruction_fetch_if.master   bus
);

  fetch_state_t      state, next_state;
  instr_t            word;

  logic [ADDR_W-1:0] pc;
  logic              pc_load;
  logic              pc_hold;
  logic [ADDR_W-1:0] pc_target;
  logic              do_fetch;

  logic              valid_q, valid_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [REG_W-1:0]  dst_q, dst_d;
  logic [REG_W-1:0]  src_a_q, src_a_d;
  logic [REG_W-1:0]  src_b_q, src_b_d;
  logic [ADDR_W-1:0] imm_q, imm_d;

  assign word = instr_t'(bus.iInstruction);

  program_counter u_pc (
    .Clock  (Clock),
    .Reset  (Reset),
    .load   (pc_load),
    .hold   (pc_hold),
    .target (pc_target),
    .pc     (pc)
  );

  // START is a single bubble cycle that fetches address 0 without looking at
  // stall or redirect; RUN applies redirect > stall > JMP > sequential.
  // A redirect leaves the decoded fields untouched and only drops oValid.
  always_comb begin
    next_state = state;
    pc_load    = 1'b0;
    pc_hold    = 1'b0;
    pc_target  = pc;
    do_fetch   = 1'b0;
    valid_d    = valid_q;
    op_d       = op_q;
    dst_d      = dst_q;
    src_a_d    = src_a_q;
    src_b_d    = src_b_q;
    imm_d      = imm_q;

    case (state)
      ST_START: begin
        next_state = ST_RUN;
        do_fetch   = 1'b1;
      end
      ST_RUN: begin
        if (bus.iBranchTaken) begin
          pc_load   = 1'b1;
          pc_target = bus.iBranchTarget;
          valid_d   = 1'b0;
        end else if (bus.iStall) begin
          pc_hold   = 1'b1;
        end else begin
          do_fetch  = 1'b1;
        end
      end
      default: begin
        next_state = ST_START;
      end
    endcase

    // JMP is resolved here and never reaches the issue slot.
    if (do_fetch) begin
      if (word.op == OP_JMP) begin
        pc_load   = 1'b1;
        pc_target = imm_of(word);
        valid_d   = 1'b0;
      end else begin
        valid_d   = 1'b1;
        op_d      = word.op;
        dst_d     = word.dst;
        src_a_d   = word.src_a;
        src_b_d   = word.src_b;
        imm_d     = imm_of(word);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= ST_START;
      valid_q <= 1'b0;
      op_q    <= '0;
      dst_q   <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      imm_q   <= '0;
    end else begin
      state   <= next_state;
      valid_q <= valid_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      src_a_q <= src_a_d;
      src_b_q <= src_b_d;
      imm_q   <= imm_d;
    end
  end

  assign bus.oAddress     = pc;
  assign bus.oValid       = valid_q;
  assign bus.oOperation   = op_q;
  assign bus.oDestination = dst_q;
  assign bus.oSourceA     = src_a_q;
  assign bus.oSourceB     = src_b_q;
  assign bus.oImmediate   = imm_q;

endmodule
